// File: rtl/uart_reg_loader.sv
// rtl/uart_reg_loader.sv - 8N1 serial receiver that decodes two-byte packets into APU register writes
`timescale 1ns/1ps
module uart_reg_loader #(
    parameter int OSCRATE      = 12_000_000,
    parameter int BAUDRATE     = 9600,
    parameter int TIMEOUT_BITS = 20,
    parameter int LINK_CYCLES  = OSCRATE / 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_we,
    output logic       link,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = OSCRATE / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BCW          = $clog2(CLKS_PER_BIT);
    localparam int TOW          = $clog2(TO_LIMIT + 1);
    localparam int LKW          = $clog2(LINK_CYCLES + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(HALF_BIT - 1);
    localparam logic [TOW-1:0] TO_MAX    = TOW'(TO_LIMIT);
    localparam logic [LKW-1:0] LINK_MAX  = LKW'(LINK_CYCLES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {P_ADDR, P_DATA} p_state_t;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync_prev;
    logic            w_fall;

    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [BCW-1:0]  r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_cnt_clr;
    logic            w_shift_en;
    logic            w_byte_valid;
    logic            w_stop_bad;

    p_state_t        r_p_state;
    p_state_t        w_p_next;
    logic [4:0]      r_addr_latch;
    logic [TOW-1:0]  r_to_cnt;
    logic            w_timeout;
    logic            w_addr_load;
    logic            w_write;

    logic [4:0]      r_addr;
    logic [7:0]      r_data;
    logic            r_we;
    logic            r_frame_err;
    logic [LKW-1:0]  r_link_cnt;

    // Synchronizer and edge history idle high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_fall = r_sync_prev & ~r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_byte_valid = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_rx_state)
            IDLE: begin
                if (w_fall) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = START;
                end
            end
            START: begin
                if (r_bit_cnt == HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_rx_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = IDLE;
                    if (r_sync2) begin
                        w_byte_valid = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end
            end
            default: w_rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_cnt_clr || (r_rx_state == IDLE)) begin
                r_bit_cnt <= '0;
            end else if (r_bit_cnt != BIT_LAST) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_rx_state == START) begin
                r_bit_idx <= '0;
            end else if (w_shift_en && (r_bit_idx != 3'd7)) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            // LSB arrives first, so shift in from the top
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    assign w_timeout = (r_to_cnt == TO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_state <= P_ADDR;
        end else begin
            r_p_state <= w_p_next;
        end
    end

    always_comb begin
        w_p_next    = r_p_state;
        w_addr_load = 1'b0;
        w_write     = 1'b0;
        case (r_p_state)
            P_ADDR: begin
                if (w_byte_valid && (r_shift[7:5] == 3'b100)) begin
                    w_addr_load = 1'b1;
                    w_p_next    = P_DATA;
                end
            end
            P_DATA: begin
                // A byte landing on the timeout cycle still counts as data
                if (w_byte_valid) begin
                    w_write  = 1'b1;
                    w_p_next = P_ADDR;
                end else if (w_stop_bad || w_timeout) begin
                    w_p_next = P_ADDR;
                end
            end
            default: w_p_next = P_ADDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_latch <= '0;
            r_to_cnt     <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_addr_load) begin
                r_addr_latch <= r_shift[4:0];
            end
            if (w_addr_load || (r_p_state == P_ADDR)) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_we        <= w_write;
            r_frame_err <= w_stop_bad;
            if (w_write) begin
                r_addr <= r_addr_latch;
                r_data <= r_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_cnt <= '0;
        end else if (w_byte_valid) begin
            r_link_cnt <= LINK_MAX;
        end else if (r_link_cnt != '0) begin
            r_link_cnt <= r_link_cnt - 1'b1;
        end
    end

    assign reg_addr  = r_addr;
    assign reg_data  = r_data;
    assign reg_we    = r_we;
    assign frame_err = r_frame_err;
    assign link      = (r_link_cnt != '0);

endmodule

// File: tb/tb_uart_reg_loader.sv
// tb/tb_uart_reg_loader.sv - byte-table and scoreboard bench for uart_reg_loader
`timescale 1ns/1ps
module tb_uart_reg_loader;

    localparam int OSC   = 153_600;
    localparam int BAUD  = 9600;
    localparam int CPB   = OSC / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int TOB   = 20;
    localparam int LINKC = 2000;
    // start edge to reg_we: 2 sync flops + edge detect, half bit, 8 data bits + stop bit
    localparam int LAT   = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we;
    logic       link;
    logic       frame_err;

    uart_reg_loader #(
        .OSCRATE(OSC), .BAUDRATE(BAUD), .TIMEOUT_BITS(TOB), .LINK_CYCLES(LINKC)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .reg_addr(reg_addr), .reg_data(reg_data),
        .reg_we(reg_we), .link(link), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap;
        logic       glitch;
        logic       exp_we;
        logic [4:0] a;
        logic [7:0] d;
        logic       exp_fe;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   writes = 0;
    int   fes = 0;
    int   last_we_cyc = 0;
    int   last_fe_cyc = 0;
    logic prev_we = 1'b0;
    logic prev_fe = 1'b0;
    wr_t  sb[$];
    vec_t vq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_we) chk("we_one_clock", {31'd0, reg_we}, 32'd0);
            if (prev_fe) chk("fe_one_clock", {31'd0, frame_err}, 32'd0);
            if (reg_we) begin
                writes++;
                last_we_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected", reg_addr, reg_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", {27'd0, reg_addr}, {27'd0, e.a});
                    chk("wr_data", {24'd0, reg_data}, {24'd0, e.d});
                end
            end
            if (frame_err) begin
                fes++;
                last_fe_cyc = cyc;
            end
            prev_we = reg_we;
            prev_fe = frame_err;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "watchdog");
    end

    // Caller must be sitting on a negedge; the start bit begins immediately
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
        rx = 1'b0;
        t0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic add(input logic [7:0] b, input logic stop, input int gap, input logic glitch,
                       input logic exp_we, input logic [4:0] a, input logic [7:0] d, input logic exp_fe);
        vec_t v;
        v.b = b; v.stop = stop; v.gap = gap; v.glitch = glitch;
        v.exp_we = exp_we; v.a = a; v.d = d; v.exp_fe = exp_fe;
        vq.push_back(v);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"}, {27'd0, reg_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, reg_data}, 32'd0);
        chk({tag, "_we"}, {31'd0, reg_we}, 32'd0);
        chk({tag, "_link"}, {31'd0, link}, 32'd0);
        chk({tag, "_fe"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int exp_writes;
        int exp_fes;
        exp_writes = 0;
        exp_fes = 0;

        add(8'h83, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h3F, 1, 2,  0, 1, 5'h03, 8'h3F, 0);
        add(8'h15, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'hA0, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h7F, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h80, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h01, 1, 2,  0, 1, 5'h00, 8'h01, 0);
        add(8'h97, 1, 25, 0, 0, 5'h00, 8'h00, 0);
        add(8'h55, 1, 2,  0, 0, 5'h00, 8'h00, 0);
        add(8'h97, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h55, 1, 2,  0, 1, 5'h17, 8'h55, 0);
        add(8'h81, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h42, 0, 2,  0, 0, 5'h00, 8'h00, 1);
        add(8'h82, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h10, 1, 2,  0, 1, 5'h02, 8'h10, 0);
        add(8'h88, 1, 2,  1, 0, 5'h00, 8'h00, 0);
        add(8'h22, 1, 2,  0, 1, 5'h08, 8'h22, 0);
        add(8'h80, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'h00, 1, 0,  0, 1, 5'h00, 8'h00, 0);
        add(8'h81, 1, 0,  0, 0, 5'h00, 8'h00, 0);
        add(8'hFF, 1, 2,  0, 1, 5'h01, 8'hFF, 0);
        add(8'h9F, 1, 9,  0, 0, 5'h00, 8'h00, 0);
        add(8'hE5, 1, 2,  0, 1, 5'h1F, 8'hE5, 0);

        repeat (4) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            if (v.exp_we) begin
                wr_t w;
                w.a = v.a;
                w.d = v.d;
                sb.push_back(w);
                exp_writes++;
            end
            if (v.exp_fe) exp_fes++;
            send_byte(v.b, v.stop, t0);
            repeat (v.gap * CPB) @(negedge clk);
            if (v.glitch) begin
                rx = 1'b0;
                repeat (5) @(negedge clk);
                rx = 1'b1;
                repeat (4 * CPB) @(negedge clk);
            end
            chk($sformatf("writes_%0d", i), writes, exp_writes);
            chk($sformatf("frame_errs_%0d", i), fes, exp_fes);
            chk($sformatf("link_%0d", i), {31'd0, link}, 32'd1);
            if (v.exp_we) chk($sformatf("we_latency_%0d", i), last_we_cyc - t0, LAT);
            if (v.exp_fe) chk($sformatf("fe_latency_%0d", i), last_fe_cyc - t0, LAT);
        end

        send_byte(8'h85, 1'b1, t0);
        fork
            send_byte(8'h44, 1'b1, t1);
            begin
                repeat (5 * CPB) @(negedge clk);
                chk("link_before_rst", {31'd0, link}, 32'd1);
                rst = 1'b1;
                #1;
                chk_outputs_zero("midbyte_rst");
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        chk("writes_after_rst", writes, exp_writes);
        chk("link_after_rst", {31'd0, link}, 32'd0);

        send_byte(8'h44, 1'b1, t0);
        chk("link_refresh", {31'd0, link}, 32'd1);
        while (cyc < t0 + LAT + LINKC - 1) @(negedge clk);
        chk("link_hold_last", {31'd0, link}, 32'd1);
        @(negedge clk);
        chk("link_drop", {31'd0, link}, 32'd0);
        repeat (2 * CPB) @(negedge clk);
        chk("writes_final", writes, exp_writes);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_loader.md
Name: uart_reg_loader

Overview:
- Upstream stage of the APU. Receives 8N1 serial bytes from the host COM port on the rx pin and decodes two-byte write packets.
- Each decoded packet becomes a single-cycle register-write strobe (reg_addr, reg_data, reg_we) into the APU register file (addresses 0x00-0x1F, NES $4000-$401F map).
- Also produces the link activity indicator and a framing-error pulse for status/debug.

Parameters:
- OSCRATE, 12_000_000, system clock frequency in Hz.
- BAUDRATE, 9600, serial bit rate. CLKS_PER_BIT = OSCRATE/BAUDRATE (1250 at defaults); HALF_BIT = CLKS_PER_BIT/2 (625).
- TIMEOUT_BITS, 20, bit-times allowed between the address byte and the data byte.
- LINK_CYCLES, OSCRATE/20, link hold time in clocks (50 ms).

Ports:
- clk  input  1  system clock (OSCRATE).
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial input, idle high.
- reg_addr  output  5  register address of the current write.
- reg_data  output  8  register data of the current write.
- reg_we  output  1  one-clock write strobe; addr/data valid while high.
- link  output  1  high while serial activity was seen in the last LINK_CYCLES.
- frame_err  output  1  one-clock pulse on a bad stop bit.

Behaviour:
- Reset values: reg_addr=0, reg_data=0, reg_we=0, link=0, frame_err=0. Both synchronizer flops reset to 1. RX FSM resets to IDLE, parser to P_ADDR, all counters to 0. Reset mid-byte or mid-packet abandons it; no strobe is issued.
- Input sync: rx passes through a 2-flop synchronizer. A falling edge is synced value 0 with the previous synced value 1.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, load the bit counter and enter START.
  - START: after HALF_BIT clocks, sample. If 1, treat as a glitch and return to IDLE. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT at bit centres, LSB first, 8 bits, then enter STOP.
  - STOP: sample after CLKS_PER_BIT. If 1, pulse byte_valid (internal) for 1 clock. If 0, pulse frame_err for 1 clock and discard the byte. Either way return to IDLE in the same cycle, so a start edge beginning half a bit later is caught.
- Parser states are P_ADDR and P_DATA.
  - P_ADDR, byte with bit7=1 and bits6:5=00: latch addr=byte[4:0], enter P_DATA, clear the timeout counter.
  - P_ADDR, any other byte: ignore it and stay.
  - P_DATA, any valid byte (including bit7=1): reg_data<=byte, reg_addr<=latched addr, and reg_we=1 for exactly one clock starting the cycle after byte_valid. Then return to P_ADDR.
  - P_DATA timeout: the counter counts clocks. At TIMEOUT_BITS*CLKS_PER_BIT with no byte_valid, return to P_ADDR without a write.
  - P_DATA frame_err: return to P_ADDR without a write.
  - Simultaneous timeout and byte_valid: byte_valid wins and the write occurs.
- Write latency: reg_we rises 1 clock after the stop-bit sample cycle. reg_addr and reg_data hold their values until the next write.
- link: each byte_valid reloads a down-counter with LINK_CYCLES and sets link=1. link=0 when the counter reaches 0. Framing errors do not refresh it.
- Widths: bit counter ceil(log2(CLKS_PER_BIT)) bits; timeout and link counters sized for their maxima. No wrap-around is permitted; counters saturate or stop at their terminal count.

Test Plan:
- Send 0x83 then 0x3F at 9600 baud -> exactly one reg_we pulse 1 clock after the second stop-bit sample, with reg_addr=0x03, reg_data=0x3F. link=1 from the first byte.
- Send 0x15, 0xA0, 0x7F -> 0x15 ignored; 0xA0 is rejected (bits6:5≠00) and ignored; no reg_we. Parser remains in P_ADDR (verify with a follow-up 0x80,0x01 producing addr 0x00, data 0x01).
- Send 0x97, idle 25 bit-times, then 0x55 -> no write (timeout). A following 0x97,0x55 back-to-back -> write addr 0x17, data 0x55.
- Send 0x81 then a data byte with the stop bit forced low -> frame_err one-clock pulse, no reg_we, parser in P_ADDR.
- rx low glitch of 300 clocks while idle -> no byte, no frame_err. Back-to-back packets 0x80,0x00,0x81,0xFF with no idle gap -> two writes (0x00/0x00, 0x01/0xFF).
- Assert rst during the DATA bits of the second packet byte -> all outputs 0 immediately; no strobe. link falls 0 and stays 0 until the next valid byte, then drops LINK_CYCLES clocks after the last byte.
